mem_port_arbiter: RTL

//   Round-robin arbiter sharing the single image-memory port between NUM_REQ

---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared image-memory port: registered one-hot grants,
// bounded bursts, and a one-cycle turnaround gap between owners.
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned ID_W      = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               preempt
);

    localparam int unsigned         CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [NUM_REQ-1:0]  ONE_HOT = NUM_REQ'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [ID_W-1:0]     LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               preempt_q, preempt_d;

    logic               found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    scan_id;
    logic [ID_W-1:0]    rel_ptr;

    // Scan ptr, ptr+1, ... modulo NUM_REQ; first active request wins.
    always_comb begin
        found   = 1'b0;
        win_id  = '0;
        scan_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_id = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && req[scan_id]) begin
                found  = 1'b1;
                win_id = scan_id;
            end
        end
    end

    assign rel_ptr = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                if (found) begin
                    state_d  = GRANT;
                    gnt_d    = ONE_HOT << win_id;
                    gnt_id_d = win_id;
                    cnt_d    = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id_q] || cnt_q == CNT_MAX) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    ptr_d     = rel_ptr;
                    preempt_d = req[gnt_id_q];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = |gnt_q;
    assign preempt = preempt_q;

endmodule
